// File: rtl/sync_capture_reg_vec_pkg.sv
// Shared constants and helpers for the multi-channel synchronizing capture register.
// Holds parameter defaults, legal parameter limits and the per-bit edge-detect function.
package sync_capture_reg_vec_pkg;

  localparam int DEFAULT_WIDTH  = 2;
  localparam int DEFAULT_STAGES = 2;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 0;
  localparam int STAGES_MAX = 4;

  // Reports a rising or falling transition, each gated by its own enable.
  function automatic logic edge_bit(input logic q, input logic prev,
                                    input logic rise_en, input logic fall_en);
    return (q & ~prev & rise_en) | (~q & prev & fall_en);
  endfunction

endpackage

// File: rtl/sync_capture_reg_vec_chain.sv
// Single-channel synchronizer: a shift chain of max(STAGES,1) flops with a synchronous reset value.
module sync_capture_chain
  import sync_capture_reg_vec_pkg::*;
#(
  parameter int   STAGES      = DEFAULT_STAGES,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  // A zero-stage request still gets one flop so the output is always registered.
  localparam int DEPTH = (STAGES < 1) ? 1 : STAGES;

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= {DEPTH{RESET_VALUE}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/sync_capture_reg_vec.sv
// Multi-channel synchronizer with sticky edge-capture pending bits and a masked interrupt.
// Each channel is synchronized independently; only the interrupt OR combines channels.
module sync_capture_reg_vec
  import sync_capture_reg_vec_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               STAGES      = DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RISE_MASK   = '1,
  parameter logic [WIDTH-1:0] FALL_MASK   = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_d,
  output logic [WIDTH-1:0] io_q,
  input  logic             io_en,
  input  logic [WIDTH-1:0] io_set,
  input  logic [WIDTH-1:0] io_clr,
  input  logic [WIDTH-1:0] io_mask,
  output logic [WIDTH-1:0] io_pend,
  output logic             io_irq
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("sync_capture_reg_vec: WIDTH %0d out of range", WIDTH);
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_stages_check
    $error("sync_capture_reg_vec: STAGES %0d out of range", STAGES);
  end

  logic [WIDTH-1:0] q_prev;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] pend_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_capture_chain #(
      .STAGES      (STAGES),
      .RESET_VALUE (RESET_VALUE[i])
    ) u_chain (
      .clock (clock),
      .reset (reset),
      .d     (io_d[i]),
      .q     (io_q[i])
    );
  end

  // Set and edge capture are ORed after the clear so they win a same-cycle collision.
  always_comb begin
    edge_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_vec[i] = edge_bit(io_q[i], q_prev[i], RISE_MASK[i], FALL_MASK[i]);
    end
    pend_next = (io_pend & ~io_clr) | (edge_vec & {WIDTH{io_en}}) | io_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_prev  <= RESET_VALUE;
      io_pend <= '0;
      io_irq  <= 1'b0;
    end else begin
      q_prev  <= io_q;
      io_pend <= pend_next;
      io_irq  <= |(io_pend & io_mask);
    end
  end

endmodule

// File: tb/tb_sync_capture_reg_vec.sv
// Directed bench for sync_capture_reg_vec: four parameterizations share one stimulus stream.
module tb_sync_capture_reg_vec;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] io_d, io_set, io_clr, io_mask;
  logic       io_en;

  logic [1:0] q_a, pend_a, q_b, pend_b, q_c, pend_c, q_d, pend_d;
  logic       irq_a, irq_b, irq_c, irq_d;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Default parameters.
  sync_capture_reg_vec dut_a (
    .clock(clock), .reset(reset), .io_d(io_d), .io_q(q_a), .io_en(io_en),
    .io_set(io_set), .io_clr(io_clr), .io_mask(io_mask), .io_pend(pend_a), .io_irq(irq_a));

  sync_capture_reg_vec #(.RESET_VALUE(2'b10)) dut_b (
    .clock(clock), .reset(reset), .io_d(io_d), .io_q(q_b), .io_en(io_en),
    .io_set(io_set), .io_clr(io_clr), .io_mask(io_mask), .io_pend(pend_b), .io_irq(irq_b));

  sync_capture_reg_vec #(.RISE_MASK(2'b00), .FALL_MASK(2'b01)) dut_c (
    .clock(clock), .reset(reset), .io_d(io_d), .io_q(q_c), .io_en(io_en),
    .io_set(io_set), .io_clr(io_clr), .io_mask(io_mask), .io_pend(pend_c), .io_irq(irq_c));

  sync_capture_reg_vec #(.STAGES(0)) dut_d (
    .clock(clock), .reset(reset), .io_d(io_d), .io_q(q_d), .io_en(io_en),
    .io_set(io_set), .io_clr(io_clr), .io_mask(io_mask), .io_pend(pend_d), .io_irq(irq_d));

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] d, input logic en, input logic [1:0] set,
                               input logic [1:0] clr, input logic [1:0] mask);
    io_d    = d;
    io_en   = en;
    io_set  = set;
    io_clr  = clr;
    io_mask = mask;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset held three cycles with the input matching dut_b's reset value.
    reset = 1'b1;
    applyStimulus(2'b10, 1'b1, 2'b00, 2'b00, 2'b11);
    step(3);
    checkOutput("rst_q_a", q_a, 2'b00);
    checkOutput("rst_pend_a", pend_a, 2'b00);
    checkOutput("rst_irq_a", irq_a, 1'b0);
    checkOutput("rst_q_b", q_b, 2'b10);
    checkOutput("rst_pend_b", pend_b, 2'b00);
    checkOutput("rst_irq_b", irq_b, 1'b0);

    reset = 1'b0;
    step(4);
    checkOutput("rel_q_b", q_b, 2'b10);
    checkOutput("rel_pend_b", pend_b, 2'b00);
    checkOutput("rel_irq_b", irq_b, 1'b0);
    checkOutput("rel_pend_a", pend_a, 2'b10);
    checkOutput("rel_irq_a", irq_a, 1'b1);
    checkOutput("rel_pend_c", pend_c, 2'b00);

    applyStimulus(2'b10, 1'b1, 2'b00, 2'b11, 2'b11);
    step(1);
    applyStimulus(2'b10, 1'b1, 2'b00, 2'b00, 2'b11);
    step(1);
    checkOutput("clr_pend_a", pend_a, 2'b00);
    checkOutput("clr_irq_a", irq_a, 1'b0);

    // Latency: bit 0 rises, only channel 0 unmasked.
    applyStimulus(2'b11, 1'b1, 2'b00, 2'b00, 2'b01);
    step(1);
    checkOutput("lat_c1_q_a", q_a, 2'b10);
    checkOutput("lat_c1_q_d", q_d, 2'b11);
    step(1);
    checkOutput("lat_c2_q_a", q_a, 2'b11);
    checkOutput("lat_c2_pend_a", pend_a, 2'b00);
    checkOutput("lat_c2_pend_d", pend_d, 2'b01);
    step(1);
    checkOutput("lat_c3_pend_a", pend_a, 2'b01);
    checkOutput("lat_c3_irq_a", irq_a, 1'b0);
    step(1);
    checkOutput("lat_c4_irq_a", irq_a, 1'b1);

    // Set/clear collision on bit 1.
    applyStimulus(2'b11, 1'b1, 2'b10, 2'b00, 2'b01);
    step(1);
    checkOutput("set_pend_a", pend_a, 2'b11);
    applyStimulus(2'b11, 1'b1, 2'b10, 2'b10, 2'b01);
    step(1);
    checkOutput("coll_pend_a", pend_a, 2'b11);
    applyStimulus(2'b11, 1'b1, 2'b00, 2'b10, 2'b01);
    step(1);
    checkOutput("clr1_pend_a", pend_a, 2'b01);

    // Mask changes affect only the interrupt.
    applyStimulus(2'b11, 1'b1, 2'b00, 2'b00, 2'b00);
    step(1);
    checkOutput("mask0_pend_a", pend_a, 2'b01);
    checkOutput("mask0_irq_a", irq_a, 1'b0);
    applyStimulus(2'b11, 1'b1, 2'b00, 2'b00, 2'b01);
    step(1);
    checkOutput("mask1_irq_a", irq_a, 1'b1);

    applyStimulus(2'b11, 1'b1, 2'b00, 2'b11, 2'b01);
    step(1);
    applyStimulus(2'b11, 1'b1, 2'b00, 2'b00, 2'b01);
    step(1);
    checkOutput("clr_all_pend_a", pend_a, 2'b00);
    checkOutput("clr_all_pend_c", pend_c, 2'b00);

    // Enable gating: bit 0 falls then rises with capture disabled.
    applyStimulus(2'b10, 1'b0, 2'b00, 2'b00, 2'b01);
    step(3);
    applyStimulus(2'b11, 1'b0, 2'b00, 2'b00, 2'b01);
    step(2);
    checkOutput("en0_q_a", q_a, 2'b11);
    step(2);
    checkOutput("en0_pend_a", pend_a, 2'b00);
    checkOutput("en0_pend_c", pend_c, 2'b00);
    applyStimulus(2'b11, 1'b1, 2'b00, 2'b00, 2'b01);
    step(2);
    checkOutput("en1_pend_a", pend_a, 2'b00);

    // Fall mode on dut_c: both bits fall, then bit 1 rises.
    applyStimulus(2'b00, 1'b1, 2'b00, 2'b00, 2'b01);
    step(3);
    checkOutput("fall_pend_c", pend_c, 2'b01);
    checkOutput("fall_pend_a", pend_a, 2'b00);
    applyStimulus(2'b10, 1'b1, 2'b00, 2'b00, 2'b01);
    step(3);
    checkOutput("fall_b1_pend_c", pend_c, 2'b01);
    checkOutput("rise_b1_pend_a", pend_a, 2'b10);

    // Mid-operation reset with a set pulse that reset must override.
    applyStimulus(2'b10, 1'b1, 2'b00, 2'b00, 2'b11);
    step(1);
    checkOutput("pre_rst_irq_a", irq_a, 1'b1);
    reset = 1'b1;
    applyStimulus(2'b10, 1'b1, 2'b11, 2'b00, 2'b11);
    step(1);
    checkOutput("mid_rst_pend_a", pend_a, 2'b00);
    checkOutput("mid_rst_irq_a", irq_a, 1'b0);
    checkOutput("mid_rst_q_a", q_a, 2'b00);
    checkOutput("mid_rst_q_b", q_b, 2'b10);
    checkOutput("mid_rst_pend_c", pend_c, 2'b00);
    reset = 1'b0;
    applyStimulus(2'b10, 1'b1, 2'b00, 2'b00, 2'b11);
    step(1);
    checkOutput("post_rst_irq_a", irq_a, 1'b0);
    checkOutput("post_rst_pend_b", pend_b, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_capture_reg_vec.md
SYNC_CAPTURE_REG_VEC -- requirements
Module: sync_capture_reg_vec

Interface
REQ-001 Parameter WIDTH, default 2, number of independent channels (legal 1..64).
REQ-002 Parameter STAGES, default 2, synchronizer flop depth per channel (legal 0..4).
REQ-003 Parameter RESET_VALUE, default all-0, WIDTH-bit reset value of chain and io_q.
REQ-004 Parameter RISE_MASK, default all-1, WIDTH-bit per-channel enable of rising-edge capture.
REQ-005 Parameter FALL_MASK, default all-0, WIDTH-bit per-channel enable of falling-edge capture.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 io_d  input  WIDTH  raw channel inputs, asynchronous to clock.
REQ-009 io_q  output  WIDTH  synchronized channel levels.
REQ-010 io_en  input  1  capture enable; low blocks edge capture into pending.
REQ-011 io_set  input  WIDTH  software set of pending bits, one-cycle pulse per bit.
REQ-012 io_clr  input  WIDTH  write-1-to-clear of pending bits.
REQ-013 io_mask  input  WIDTH  interrupt enable per channel.
REQ-014 io_pend  output  WIDTH  sticky pending bits.
REQ-015 io_irq  output  1  registered OR of (pending AND mask).

Function
REQ-016 Each channel SHALL pass io_d through max(STAGES,1) flops; io_q is the last flop; io_d-to-io_q latency = max(STAGES,1) cycles.
REQ-017 A previous-value register q_prev SHALL hold io_q delayed one cycle.
REQ-018 rise[i] SHALL equal io_q[i] & ~q_prev[i] & RISE_MASK[i]; fall[i] SHALL equal ~io_q[i] & q_prev[i] & FALL_MASK[i].
REQ-019 Next pending SHALL be (pend & ~io_clr) | ((rise|fall) & {WIDTH{io_en}}) | io_set.
REQ-020 Simultaneous clear and (edge or set) on one bit: set/edge wins, bit remains 1.
REQ-021 io_pend SHALL update one cycle after the edge appears on io_q (pending latency from io_d = max(STAGES,1)+1).
REQ-022 io_irq SHALL be registered from current io_pend & io_mask, asserting one cycle after the qualifying pending bit.
REQ-023 Mask changes SHALL not alter io_pend; they affect io_irq on the next cycle only.
REQ-024 io_en low SHALL not stall the chain; io_q and q_prev continue tracking; only capture is suppressed, with no deferred capture when io_en returns high.
REQ-025 Channels SHALL be fully independent; no cross-channel interaction except the OR in io_irq.

Reset
REQ-026 While reset is high at a clock edge, all chain flops, io_q and q_prev SHALL load RESET_VALUE, io_pend 0, io_irq 0.
REQ-027 Reset SHALL override io_set, io_clr and any edge in the same cycle.
REQ-028 First cycle after reset release: no edge is reported unless io_q has since changed from RESET_VALUE.
REQ-029 Reset asserted mid-operation SHALL discard in-flight chain values and pending bits without producing an io_irq pulse.

Structure
REQ-030 Shared package SHALL hold default parameter values, the WIDTH/STAGES legal limits, and an edge-detect function.
REQ-031 One sub-module sync_capture_chain SHALL implement a single-channel STAGES-deep synchronizer with synchronous reset value; top instantiates WIDTH copies.
REQ-032 Illegal WIDTH or STAGES SHALL be rejected at elaboration.

Verification
REQ-033 Reset: RESET_VALUE=2'b10, hold reset 3 cycles -> io_q=2'b10, io_pend=0, io_irq=0; no pend after release with io_d=2'b10.
REQ-034 Latency: STAGES=2, io_d[0] 0->1 at cycle 0, mask=1, en=1 -> io_q[0]=1 at cycle 2, io_pend[0]=1 at cycle 3, io_irq=1 at cycle 4.
REQ-035 Clear/set collision: io_pend[1]=1; drive io_clr[1]=1 and io_set[1]=1 same cycle -> io_pend[1] stays 1; io_clr alone next cycle -> 0.
REQ-036 Enable gating: io_en=0, toggle io_d[0] 0->1 -> io_q follows, io_pend stays 0; io_en=1 afterwards -> io_pend stays 0.
REQ-037 Fall mode: FALL_MASK=2'b01, RISE_MASK=2'b00, io_d[0] 1->0 -> io_pend[0]=1; io_d[1] any toggle -> io_pend[1]=0.
REQ-038 Mid-operation reset: pending set and io_irq=1, assert reset 1 cycle -> next cycle io_pend=0, io_irq=0, io_q=RESET_VALUE.
